// File: rtl/if_fetch_ctrl_if.sv
// Memory-side fetch bus: request/acknowledge handshake plus returned instruction data.
// The fetch controller is the master; the instruction memory is the slave.
interface if_fetch_ctrl_if #(
    parameter int DATA_W = 32
);
    // mem_req rises to start a fetch and stays high through the cycle mem_ack=1;
    // mem_ack=1 means mem_rdata is valid and the request is complete.
    logic              mem_req;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, output mem_ack, output mem_rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: issues req/ack fetches, holds the instruction for decode,
// squashes on taken branches and flags a non-responding memory. Optional FETCH_PERF_EN adds perf counters.
module if_fetch_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 64,
    parameter int TO_CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              br_taken,
    if_fetch_ctrl_if.master   mem,
    output logic              pc_en,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic              flush_out,
    output logic              fetch_err,
    output logic [1:0]        fsm_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(ACK_TIMEOUT);
    localparam logic [TO_CNT_W-1:0] TO_MAX   = '1;

    state_t              state;
    logic                req_q;
    logic [TO_CNT_W-1:0] to_cnt;
    logic [TO_CNT_W-1:0] to_inc;
    logic                to_hit;

    assign mem.mem_req = req_q;
    assign fsm_state   = state;
    // A branch redirects the PC immediately, even while decode is stalled.
    assign pc_en       = br_taken | ((state == HOLD) & ~stall_in);

    always_comb begin
        to_inc = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;
        to_hit = (ACK_TIMEOUT != 0) && (to_inc == TO_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            flush_out  <= 1'b0;
            fetch_err  <= 1'b0;
            to_cnt     <= '0;
        end else begin
            flush_out <= br_taken;
            case (state)
                IDLE: begin
                    if (!br_taken) begin
                        state  <= REQ;
                        req_q  <= 1'b1;
                        to_cnt <= '0;
                    end
                end
                REQ: begin
                    if (br_taken && mem.mem_ack) begin
                        state  <= IDLE;
                        req_q  <= 1'b0;
                        to_cnt <= '0;
                    end else if (br_taken) begin
                        // The accepted request must still complete; wait it out in DRAIN.
                        state  <= DRAIN;
                        to_cnt <= '0;
                    end else if (mem.mem_ack) begin
                        state      <= HOLD;
                        req_q      <= 1'b0;
                        inst_valid <= 1'b1;
                        inst_out   <= mem.mem_rdata;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_inc;
                        if (to_hit) fetch_err <= 1'b1;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        state      <= IDLE;
                        inst_valid <= 1'b0;
                    end else if (!stall_in) begin
                        state      <= REQ;
                        req_q      <= 1'b1;
                        inst_valid <= 1'b0;
                        to_cnt     <= '0;
                    end
                end
                DRAIN: begin
                    if (mem.mem_ack) begin
                        state  <= IDLE;
                        req_q  <= 1'b0;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_inc;
                        if (to_hit) fetch_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if ((state == HOLD) && stall_in)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (((state == REQ) || (state == DRAIN)) && !mem.mem_ack)
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed, table-driven bench for if_fetch_ctrl (built with ACK_TIMEOUT=4); each row gives
// the inputs for one cycle and the outputs expected during that cycle, before its clock edge.
module tb_if_fetch_ctrl;

    localparam int DATA_W = 32;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic        pc;
        logic        valid;
        logic [31:0] inst;
        logic        flush;
        logic        err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        br_taken;
    logic        pc_en;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic        flush_out;
    logic        fetch_err;
    logic [1:0]  fsm_state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[32];

    if_fetch_ctrl_if #(.DATA_W(DATA_W)) mem_bus ();

    if_fetch_ctrl #(
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (4),
        .TO_CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_in   (stall_in),
        .br_taken   (br_taken),
        .mem        (mem_bus),
        .pc_en      (pc_en),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .flush_out  (flush_out),
        .fetch_err  (fetch_err),
        .fsm_state  (fsm_state)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t v(logic r, logic s, logic b, logic a, logic [31:0] d,
                               logic e_req, logic e_pc, logic e_val, logic [31:0] e_inst,
                               logic e_fl, logic e_err);
        vec_t t;
        t.rst = r; t.stall = s; t.br = b; t.ack = a; t.rdata = d;
        t.req = e_req; t.pc = e_pc; t.valid = e_val; t.inst = e_inst;
        t.flush = e_fl; t.err = e_err;
        return t;
    endfunction

    task automatic drive(input logic r, input logic s, input logic b, input logic a,
                         input logic [31:0] d);
        rst               = r;
        stall_in          = s;
        br_taken          = b;
        mem_bus.mem_ack   = a;
        mem_bus.mem_rdata = d;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) next_cycle();

        //           rst stl br ack rdata          req pc val inst          fl err
        vecs[0]  = v(1, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,        0, 0);
        vecs[1]  = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,        0, 0);
        vecs[2]  = v(0, 0, 0, 1, 32'h20010005,   1, 0, 0, 32'h0,        0, 0);
        vecs[3]  = v(0, 0, 0, 0, 32'h0,          0, 1, 1, 32'h20010005, 0, 0);
        vecs[4]  = v(0, 0, 0, 1, 32'h00A00093,   1, 0, 0, 32'h20010005, 0, 0);
        vecs[5]  = v(0, 0, 0, 0, 32'h0,          0, 1, 1, 32'h00A00093, 0, 0);
        vecs[6]  = v(0, 0, 0, 1, 32'h11111111,   1, 0, 0, 32'h00A00093, 0, 0);
        vecs[7]  = v(0, 1, 0, 0, 32'h0,          0, 0, 1, 32'h11111111, 0, 0);
        vecs[8]  = v(0, 1, 0, 0, 32'h0,          0, 0, 1, 32'h11111111, 0, 0);
        vecs[9]  = v(0, 1, 0, 1, 32'hBAD0BAD0,   0, 0, 1, 32'h11111111, 0, 0);
        vecs[10] = v(0, 1, 0, 0, 32'h0,          0, 0, 1, 32'h11111111, 0, 0);
        vecs[11] = v(0, 1, 0, 0, 32'h0,          0, 0, 1, 32'h11111111, 0, 0);
        vecs[12] = v(0, 0, 0, 0, 32'h0,          0, 1, 1, 32'h11111111, 0, 0);
        vecs[13] = v(0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h11111111, 0, 0);
        vecs[14] = v(0, 0, 1, 0, 32'h0,          1, 1, 0, 32'h11111111, 0, 0);
        vecs[15] = v(0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h11111111, 1, 0);
        vecs[16] = v(0, 0, 0, 1, 32'hCAFEF00D,   1, 0, 0, 32'h11111111, 0, 0);
        vecs[17] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h11111111, 0, 0);
        vecs[18] = v(0, 0, 1, 1, 32'hDEADBEEF,   1, 1, 0, 32'h11111111, 0, 0);
        vecs[19] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h11111111, 1, 0);
        vecs[20] = v(0, 0, 0, 1, 32'h00000073,   1, 0, 0, 32'h11111111, 0, 0);
        vecs[21] = v(0, 1, 1, 0, 32'h0,          0, 1, 1, 32'h00000073, 0, 0);
        vecs[22] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00000073, 1, 0);
        vecs[23] = v(0, 0, 1, 0, 32'h0,          1, 1, 0, 32'h00000073, 0, 0);
        vecs[24] = v(0, 0, 1, 0, 32'h0,          1, 1, 0, 32'h00000073, 1, 0);
        vecs[25] = v(0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h00000073, 1, 0);
        vecs[26] = v(0, 0, 0, 1, 32'h12345678,   1, 0, 0, 32'h00000073, 0, 0);
        vecs[27] = v(0, 0, 1, 0, 32'h0,          0, 1, 0, 32'h00000073, 0, 0);
        vecs[28] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00000073, 1, 0);
        vecs[29] = v(0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h00000073, 0, 0);
        vecs[30] = v(1, 0, 0, 1, 32'h0000ABCD,   1, 0, 0, 32'h00000073, 0, 0);
        vecs[31] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,        0, 0);

        for (int i = 0; i < 32; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].ack, vecs[i].rdata);
            #1;
            check($sformatf("row%0d mem_req", i),    32'(mem_bus.mem_req), 32'(vecs[i].req));
            check($sformatf("row%0d pc_en", i),      32'(pc_en),           32'(vecs[i].pc));
            check($sformatf("row%0d inst_valid", i), 32'(inst_valid),      32'(vecs[i].valid));
            check($sformatf("row%0d inst_out", i),   inst_out,             vecs[i].inst);
            check($sformatf("row%0d flush_out", i),  32'(flush_out),       32'(vecs[i].flush));
            check($sformatf("row%0d fetch_err", i),  32'(fetch_err),       32'(vecs[i].err));
            next_cycle();
        end

        // Timeout: REQ entered cleanly after the reset row; memory stays silent for 6 cycles.
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            check($sformatf("timeout cyc%0d mem_req", k),   32'(mem_bus.mem_req), 32'd1);
            check($sformatf("timeout cyc%0d fetch_err", k), 32'(fetch_err),       32'(k >= 5));
            next_cycle();
        end
`ifdef FETCH_PERF_EN
        check("perf_wait after timeout", perf_wait_cnt, 32'd6);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000055);
        #1;
        check("late ack fetch_err", 32'(fetch_err), 32'd1);
        next_cycle();
        for (int k = 1; k <= 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            check($sformatf("post-ack stall%0d inst_valid", k), 32'(inst_valid), 32'd1);
            check($sformatf("post-ack stall%0d inst_out", k),   inst_out,        32'h00000055);
            check($sformatf("post-ack stall%0d pc_en", k),      32'(pc_en),      32'd0);
            check($sformatf("post-ack stall%0d fetch_err", k),  32'(fetch_err),  32'd1);
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("stall release pc_en", 32'(pc_en), 32'd1);
        next_cycle();
        #1;
        check("refetch mem_req", 32'(mem_bus.mem_req), 32'd1);
        check("refetch fetch_err", 32'(fetch_err), 32'd1);
`ifdef FETCH_PERF_EN
        check("perf_stall count", perf_stall_cnt, 32'd2);
        check("perf_wait stable", perf_wait_cnt, 32'd6);
`endif

        // Only reset clears the sticky error.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("reset clears fetch_err", 32'(fetch_err), 32'd0);
        check("reset mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("reset inst_out", inst_out, 32'h0);
        check("reset fsm_state", 32'(fsm_state), 32'd0);
`ifdef FETCH_PERF_EN
        check("reset perf_wait", perf_wait_cnt, 32'd0);
        check("reset perf_stall", perf_stall_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
